trap_energy_picker: RTL and testbench

Consumer of the trapezoidal shaper's output stream: detects each trapezoid by threshold crossing, waits to the flat-top, averages 2^n flat-top samples and emits one timestamped energy event on an AXI-Stream master with backpressure. Sits directly after the shaper in the DSP chain; its events feed the histogram/DMA path. Pile-up detection and drop counters are included.

---
 rtl/trap_pkg.sv | 19 +
 rtl/trap_trigger.sv | 31 +++
 rtl/trap_energy_picker.sv | 184 ++++++++++++++++++
 tb/tb_trap_energy_picker.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared types and constants for the trapezoid energy picker
package trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_SUM,
        ST_EMIT,
        ST_HOLDOFF
    } state_t;

    localparam int AVG_LOG2_MAX = 8;
    localparam int ACC_GUARD    = 8;

    function automatic logic [3:0] clamp_avg_log2(input logic [3:0] v);
        return (v > 4'(AVG_LOG2_MAX)) ? 4'(AVG_LOG2_MAX) : v;
    endfunction

endpackage

// File: rtl/trap_trigger.sv
// rtl/trap_trigger.sv - signed rising threshold-crossing detector on the shaped stream
module trap_trigger #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] tdata,
    input  logic                  tvalid,
    input  logic [DATA_WIDTH-1:0] threshold,
    output logic                  crossing
);

    logic [DATA_WIDTH-1:0] prev;
    logic                  armed;

    // The first valid sample after reset only seeds prev, so it can never trigger.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            prev  <= '0;
            armed <= 1'b0;
        end else if (tvalid) begin
            prev  <= tdata;
            armed <= 1'b1;
        end
    end

    assign crossing = tvalid && armed
                   && ($signed(prev) < $signed(threshold))
                   && ($signed(tdata) >= $signed(threshold));

endmodule

// File: rtl/trap_energy_picker.sv
// rtl/trap_energy_picker.sv - flat-top averaging energy picker with timestamped event output
module trap_energy_picker
    import trap_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TS_WIDTH   = 32
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]        threshold,
    input  logic [13:0]                  peak_delay,
    input  logic [3:0]                   avg_log2,
    input  logic [13:0]                  holdoff,
    output logic [TS_WIDTH+DATA_WIDTH-1:0] m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [15:0]                  pileup_cnt,
    output logic [15:0]                  drop_cnt
);

    localparam int ACC_W = DATA_WIDTH + ACC_GUARD;

    state_t state, state_next;

    logic                          crossing;
    logic [13:0]                   cnt, pd_lat, ho_lat, win_last;
    logic [3:0]                    n_lat;
    logic [TS_WIDTH-1:0]           ts_cnt, ts_lat;
    logic signed [ACC_W-1:0]       acc, acc_shift;
    logic [DATA_WIDTH-1:0]         energy;
    logic [TS_WIDTH+DATA_WIDTH-1:0] slot_data;
    logic                          slot_valid;
    logic [15:0]                   pileup_q, drop_q;

    logic latch, cnt_clr, cnt_inc, acc_add, pile_inc, load_slot, drop_inc;

    trap_trigger #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_trigger (
        .clk       (clk),
        .aresetn   (aresetn),
        .tdata     (s_axis_tdata),
        .tvalid    (s_axis_tvalid),
        .threshold (threshold),
        .crossing  (crossing)
    );

    assign win_last  = (14'd1 << n_lat) - 14'd1;
    assign acc_shift = acc >>> n_lat;
    assign energy    = acc_shift[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (crossing) begin
                    state_next = (peak_delay == 14'd0) ? ST_SUM : ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (crossing) begin
                    state_next = ST_HOLDOFF;
                end else if (s_axis_tvalid && cnt == pd_lat - 14'd1) begin
                    state_next = ST_SUM;
                end
            end
            ST_SUM: begin
                if (crossing) begin
                    state_next = ST_HOLDOFF;
                end else if (s_axis_tvalid && cnt == win_last) begin
                    state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                state_next = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (ho_lat == 14'd0) begin
                    state_next = ST_IDLE;
                end else if (s_axis_tvalid && !crossing && cnt == ho_lat - 14'd1) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        latch     = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        acc_add   = 1'b0;
        pile_inc  = 1'b0;
        load_slot = 1'b0;
        drop_inc  = 1'b0;
        // A crossing inside the holdoff window restarts it rather than leaving the state.
        cnt_clr   = (state_next != state) || (state == ST_HOLDOFF && crossing);
        cnt_inc   = s_axis_tvalid
                 && (state == ST_DELAY || state == ST_SUM || state == ST_HOLDOFF);
        unique case (state)
            ST_IDLE:    latch    = crossing;
            ST_DELAY:   pile_inc = crossing;
            ST_SUM: begin
                pile_inc = crossing;
                acc_add  = s_axis_tvalid && !crossing;
            end
            ST_EMIT: begin
                load_slot = !slot_valid || m_axis_tready;
                drop_inc  = slot_valid && !m_axis_tready;
            end
            ST_HOLDOFF: pile_inc = crossing;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            cnt      <= '0;
            pd_lat   <= '0;
            ho_lat   <= '0;
            n_lat    <= '0;
            ts_cnt   <= '0;
            ts_lat   <= '0;
            acc      <= '0;
            pileup_q <= '0;
            drop_q   <= '0;
        end else begin
            if (s_axis_tvalid) begin
                ts_cnt <= ts_cnt + 1'b1;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 14'd1;
            end
            if (latch) begin
                ts_lat <= ts_cnt;
                pd_lat <= peak_delay;
                ho_lat <= holdoff;
                n_lat  <= clamp_avg_log2(avg_log2);
                acc    <= '0;
            end else if (acc_add) begin
                acc <= acc + {{ACC_GUARD{s_axis_tdata[DATA_WIDTH-1]}}, s_axis_tdata};
            end
            if (pile_inc && pileup_q != 16'hFFFF) begin
                pileup_q <= pileup_q + 16'd1;
            end
            if (drop_inc && drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    // Single output slot: a load may coincide with the drain of the previous event.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            slot_valid <= 1'b0;
            slot_data  <= '0;
        end else if (load_slot) begin
            slot_valid <= 1'b1;
            slot_data  <= {ts_lat, energy};
        end else if (slot_valid && m_axis_tready) begin
            slot_valid <= 1'b0;
        end
    end

    assign m_axis_tvalid = slot_valid;
    assign m_axis_tdata  = slot_data;
    assign pileup_cnt    = pileup_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_trap_energy_picker.sv
// tb/tb_trap_energy_picker.sv - self-checking bench for trap_energy_picker
module tb_trap_energy_picker;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic [31:0] threshold;
    logic [13:0] peak_delay;
    logic [3:0]  avg_log2;
    logic [13:0] holdoff;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [15:0] pileup_cnt;
    logic [15:0] drop_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int thr, pd, avg, ho;
    int mv[$];
    int me[$];
    int pq[$];
    logic [63:0] got[$];
    logic [63:0] exp_q[$];

    trap_energy_picker #(.DATA_WIDTH(32), .TS_WIDTH(32)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .threshold     (threshold),
        .peak_delay    (peak_delay),
        .avg_log2      (avg_log2),
        .holdoff       (holdoff),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .pileup_cnt    (pileup_cnt),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) got.push_back(m_axis_tdata);
    end

    task automatic set_params(input int t, input int p, input int a, input int h);
        thr = t; pd = p; avg = a; ho = h;
        threshold = t; peak_delay = 14'(p); avg_log2 = 4'(a); holdoff = 14'(h);
    endtask

    task automatic drive(input int v, input bit vld);
        s_axis_tdata = v;
        s_axis_tvalid = vld;
        if (vld) begin
            mv.push_back(v);
            me.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 1'b0);
    endtask

    task automatic send_list(input int gap);
        foreach (pq[i]) begin
            while (gap > 0 && $urandom_range(99) < gap) drive(0, 1'b0);
            drive(pq[i], 1'b1);
        end
        pq.delete();
    endtask

    task automatic add_pulse(input int amp, input int flat_len, input int noise);
        for (int k = 0; k < 4; k++) pq.push_back(k * amp / 4);
        for (int k = 0; k < flat_len; k++) pq.push_back(amp + int'($urandom_range(noise)));
        for (int k = 3; k > 0; k--) pq.push_back(k * amp / 4);
    endtask

    task automatic add_base(input int n, input int neg);
        for (int k = 0; k < n; k++) pq.push_back(0 - int'($urandom_range(neg)));
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        mv.delete(); me.delete(); got.delete();
    endtask

    function automatic bit is_cross(int j);
        return j >= 1 && mv[j-1] < thr && mv[j] >= thr;
    endfunction

    // Event-level model: walks the recorded valid-sample stream applying the trigger,
    // window, pile-up and holdoff rules; the emit cycle swallows a sample arriving on it.
    task automatic model_run(output int pile);
        int n, k, nl, nwin;
        n = mv.size();
        nl = (avg > 8) ? 8 : avg;
        nwin = 1 << nl;
        k = 1;
        pile = 0;
        exp_q.delete();
        while (k < n) begin
            if (!is_cross(k)) begin
                k++;
                continue;
            end
            begin
                int t, ws, we, ab, j, hc;
                longint s;
                t = k; ws = t + pd + 1; we = ws + nwin - 1; ab = -1;
                for (int x = t + 1; x <= we && x < n; x++) begin
                    if (is_cross(x)) begin ab = x; break; end
                end
                if (ab >= 0) begin
                    pile++;
                    j = ab + 1;
                end else if (we >= n) begin
                    break;
                end else begin
                    s = 0;
                    for (int x = ws; x <= we; x++) s += longint'(mv[x]);
                    s = s >>> nl;
                    exp_q.push_back({32'(t), 32'(s)});
                    j = we + 1;
                    if (j < n && me[j] == me[we] + 1) j++;
                end
                hc = 0;
                while (hc < ho && j < n) begin
                    if (is_cross(j)) begin pile++; hc = 0; end
                    else hc++;
                    j++;
                end
                k = j;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%0b exp=0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 64'd0) begin failures++; $display("FAIL reset_tdata got=%0h exp=0", m_axis_tdata); end
        checks++; if (pileup_cnt !== 16'd0) begin failures++; $display("FAIL reset_pileup got=%0d exp=0", pileup_cnt); end
        checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    endtask

    task automatic test_basic(input int gap, input string tag);
        int ep;
        do_reset();
        set_params(100, 4, 2, 10);
        add_pulse(1000, 20, 0);
        add_base(10, 0);
        send_list(gap);
        idle(10);
        model_run(ep);
        checks++; if (got.size() != 1) begin failures++; $display("FAIL %s_count got=%0d exp=1", tag, got.size()); end
        else begin
            checks++; if (got[0] !== {32'd1, 32'd1000}) begin failures++; $display("FAIL %s_event got=%0h exp=%0h", tag, got[0], {32'd1, 32'd1000}); end
            checks++; if (exp_q.size() != 1 || got[0] !== exp_q[0]) begin failures++; $display("FAIL %s_model got=%0h exp_n=%0d", tag, got[0], exp_q.size()); end
        end
        checks++; if (pileup_cnt !== 16'd0) begin failures++; $display("FAIL %s_pileup got=%0d exp=0", tag, pileup_cnt); end
    endtask

    task automatic test_window_average();
        int ep;
        do_reset();
        set_params(100, 4, 2, 10);
        add_pulse(1000, 20, 0);
        pq[6] = 1000; pq[7] = 1002; pq[8] = 1004; pq[9] = 1006;
        add_base(10, 0);
        send_list(0);
        idle(10);
        model_run(ep);
        checks++; if (got.size() != 1) begin failures++; $display("FAIL avg_count got=%0d exp=1", got.size()); end
        else begin
            checks++; if (got[0] !== {32'd1, 32'd1003}) begin failures++; $display("FAIL avg_event got=%0h exp=%0h", got[0], {32'd1, 32'd1003}); end
        end
    endtask

    task automatic test_pileup();
        int ep;
        do_reset();
        set_params(100, 4, 2, 10);
        pq = '{0, 250, 50, 300};
        for (int k = 0; k < 20; k++) pq.push_back(1000);
        add_base(10, 0);
        send_list(0);
        idle(10);
        model_run(ep);
        checks++; if (got.size() != 0) begin failures++; $display("FAIL pileup_events got=%0d exp=0", got.size()); end
        checks++; if (pileup_cnt !== 16'd1) begin failures++; $display("FAIL pileup_cnt got=%0d exp=1", pileup_cnt); end
        checks++; if (pileup_cnt !== 16'(ep)) begin failures++; $display("FAIL pileup_model got=%0d exp=%0d", pileup_cnt, ep); end
    endtask

    task automatic test_back_to_back_drop();
        int ep;
        do_reset();
        m_axis_tready = 1'b0;
        set_params(100, 4, 2, 10);
        add_pulse(1000, 20, 0);
        add_base(30, 0);
        add_pulse(2000, 20, 7);
        add_base(30, 0);
        send_list(0);
        idle(5);
        model_run(ep);
        checks++; if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL drop_held_valid got=%0b exp=1", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== {32'd1, 32'd1000}) begin failures++; $display("FAIL drop_held_data got=%0h exp=%0h", m_axis_tdata, {32'd1, 32'd1000}); end
        checks++; if (exp_q.size() != 2 || m_axis_tdata !== exp_q[0]) begin failures++; $display("FAIL drop_model got=%0h exp_n=%0d", m_axis_tdata, exp_q.size()); end
        checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL drop_cnt got=%0d exp=1", drop_cnt); end
        m_axis_tready = 1'b1;
        idle(5);
        checks++; if (got.size() != 1 || got[0] !== {32'd1, 32'd1000}) begin failures++; $display("FAIL drop_release got_n=%0d exp_n=1", got.size()); end
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL drop_after_valid got=%0b exp=0", m_axis_tvalid); end
    endtask

    task automatic test_reset_mid_sum();
        int ep;
        do_reset();
        set_params(100, 4, 2, 10);
        pq = '{0, 250, 50, 300};
        for (int k = 0; k < 15; k++) pq.push_back(1000);
        add_base(5, 0);
        pq.push_back(250); pq.push_back(500); pq.push_back(750);
        for (int k = 0; k < 4; k++) pq.push_back(1000);
        send_list(0);
        checks++; if (pileup_cnt !== 16'd1) begin failures++; $display("FAIL midrst_pre_pileup got=%0d exp=1", pileup_cnt); end
        do_reset();
        checks++; if (m_axis_tvalid !== 1'b0 || pileup_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            failures++; $display("FAIL midrst_clear got_v=%0b pile=%0d drop=%0d exp=0", m_axis_tvalid, pileup_cnt, drop_cnt);
        end
        add_pulse(1000, 20, 0);
        add_base(10, 0);
        send_list(0);
        idle(10);
        model_run(ep);
        checks++; if (got.size() != 1 || got[0] !== {32'd1, 32'd1000}) begin failures++; $display("FAIL midrst_event got_n=%0d exp_n=1", got.size()); end
    endtask

    task automatic test_random();
        int ep, a;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            a = ($urandom_range(4) == 0) ? 9 + int'($urandom_range(6)) : int'($urandom_range(3));
            set_params(100, int'($urandom_range(6)), a, int'($urandom_range(12, 1)));
            add_base(int'($urandom_range(5, 1)), 50);
            for (int p = 0; p < 4; p++) begin
                add_pulse(int'($urandom_range(5000, 200)),
                          int'($urandom_range(40, 1)) + ((a > 8) ? 260 : 0),
                          int'($urandom_range(5)));
                add_base(int'($urandom_range(25)), 50);
            end
            send_list((it % 2) ? 40 : 0);
            idle(20);
            model_run(ep);
            checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, got.size(), exp_q.size()); end
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
                checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_event%0d got=%0h exp=%0h", it, i, got[i], exp_q[i]); end
            end
            checks++; if (pileup_cnt !== 16'(ep)) begin failures++; $display("FAIL rand%0d_pileup got=%0d exp=%0d", it, pileup_cnt, ep); end
            checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL rand%0d_drop got=%0d exp=0", it, drop_cnt); end
        end
    endtask

    initial begin
        aresetn = 1'b0;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        set_params(100, 4, 2, 10);
        @(posedge clk);
        #1;
        test_reset();
        test_basic(0, "basic");
        test_window_average();
        test_basic(50, "gapped");
        test_pileup();
        test_back_to_back_drop();
        test_reset_mid_sum();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
